// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the data-side memory port arbiter and its read tag
// pipeline: owner encoding, the memory read latency, and the tag record.
package mem_port_arbiter_pkg;

  // Which requester issued a read
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_AUX = 1'b1;

  // Read latency of the program/data memory (address -> data valid)
  localparam int MEM_RD_LAT = 2;

  // One in-flight read slot
  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

  localparam rd_tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_CPU};

  // Saturating 16-bit increment used by the statistics counters
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_tag_pipe.sv
// mem_rd_tag_pipe
// RD_LAT-deep shift register of {valid, owner} read tags. A tag pushed in
// cycle t appears at the tail in cycle t+RD_LAT.
// Ports:
//   clk, rst_n : clock, asynchronous active-low clear of every stage
//   push       : tag entering stage 0 at the next rising edge
//   tail       : oldest stage (registered)
module mem_rd_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = MEM_RD_LAT
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t push,
  output rd_tag_t tail
);

  rd_tag_t stages [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) stages[i] <= TAG_IDLE;
    end else begin
      stages[0] <= push;
      for (int i = 1; i < RD_LAT; i++) stages[i] <= stages[i-1];
    end
  end

  assign tail = stages[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares memory read port 1 and the write port between the CPU load/store
// stage (cpu) and an auxiliary master (aux). cpu has fixed priority; aux is
// force-granted after AUX_MAX_WAIT consecutive denied cycles. Reads are
// tagged with their owner and the tag travels RD_LAT cycles alongside the
// memory access so the returning data is flagged for the right requester.
//
// Handshake: a requester raises req with we/addr/wdata stable; gnt is
// combinational in the same cycle and means the access is issued to the
// memory this cycle. Writes need nothing more; a granted read is answered
// by exactly one rvalid cycle RD_LAT cycles later. Dropping req before gnt
// cancels the request.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   cpu_req/we/addr/wdata, cpu_gnt/rvalid/rdata   cpu requester
//   aux_req/we/addr/wdata, aux_gnt/rvalid/rdata   aux requester
//   mem_raddr, mem_rdata                memory read port 1
//   mem_wen, mem_waddr, mem_wdata       memory write port
// Optional (macro MEM_ARB_STATS_EN):
//   stat_aux_stall, stat_cpu_stall, stat_force  saturating event counters
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT       = MEM_RD_LAT,
  parameter int AUX_MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [15:0] aux_addr,
  input  logic [15:0] aux_wdata,
  output logic        aux_gnt,
  output logic        aux_rvalid,
  output logic [15:0] aux_rdata,
  output logic [15:0] mem_raddr,
  input  logic [15:0] mem_rdata,
  output logic        mem_wen,
  output logic [15:0] mem_waddr,
  output logic [15:0] mem_wdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] stat_aux_stall,
  output logic [15:0] stat_cpu_stall,
  output logic [15:0] stat_force
`endif
);

  localparam logic [7:0] MAX_WAIT = 8'(AUX_MAX_WAIT);

  logic [7:0]  wait_cnt;
  logic [15:0] last_raddr;
  logic        force_aux;
  logic        gnt_any;
  logic        gnt_we;
  logic [15:0] gnt_addr;
  logic [15:0] gnt_wdata;
  logic        rd_gnt;
  logic        wr_gnt;
  rd_tag_t     tag_push;
  rd_tag_t     tag_tail;

  // Grants are gated by rst_n so nothing is issued while reset is held.
  assign force_aux = (wait_cnt == MAX_WAIT);
  assign aux_gnt   = rst_n & aux_req & (~cpu_req | force_aux);
  assign cpu_gnt   = rst_n & cpu_req & ~aux_gnt;

  assign gnt_any   = cpu_gnt | aux_gnt;
  assign gnt_we    = aux_gnt ? aux_we    : cpu_we;
  assign gnt_addr  = aux_gnt ? aux_addr  : cpu_addr;
  assign gnt_wdata = aux_gnt ? aux_wdata : cpu_wdata;
  assign rd_gnt    = gnt_any & ~gnt_we;
  assign wr_gnt    = gnt_any & gnt_we;

  assign mem_wen   = wr_gnt;
  assign mem_waddr = wr_gnt ? gnt_addr  : 16'h0000;
  assign mem_wdata = wr_gnt ? gnt_wdata : 16'h0000;
  // Read address follows the granted read, otherwise holds the last one.
  assign mem_raddr = rd_gnt ? gnt_addr  : last_raddr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= 8'd0;
      last_raddr <= 16'h0000;
    end else begin
      if (aux_req & ~aux_gnt) begin
        if (wait_cnt != MAX_WAIT) wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end
      if (rd_gnt) last_raddr <= gnt_addr;
    end
  end

  assign tag_push.valid = rd_gnt;
  assign tag_push.owner = aux_gnt ? OWN_AUX : OWN_CPU;

  mem_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tag_push),
    .tail  (tag_tail)
  );

  assign cpu_rvalid = tag_tail.valid & (tag_tail.owner == OWN_CPU);
  assign aux_rvalid = tag_tail.valid & (tag_tail.owner == OWN_AUX);
  // Data is shared; consumers qualify it with their own rvalid.
  assign cpu_rdata  = mem_rdata;
  assign aux_rdata  = mem_rdata;

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_aux_stall <= 16'h0000;
      stat_cpu_stall <= 16'h0000;
      stat_force     <= 16'h0000;
    end else begin
      if (aux_req & ~aux_gnt)  stat_aux_stall <= sat_inc16(stat_aux_stall);
      if (cpu_req & ~cpu_gnt)  stat_cpu_stall <= sat_inc16(stat_cpu_stall);
      if (aux_gnt & force_aux) stat_force     <= sat_inc16(stat_force);
    end
  end
`else
  // Statistics counters compiled out; no extra state.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. Contains a behavioural memory
// with a 2-cycle read latency, directed scenario tasks, a randomized
// scenario, and a reference-model scoreboard that predicts grants, issued
// accesses and read responses from the arbitration rules. Define
// MEM_ARB_STATS_EN to also cover the statistics counters.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int RD_LAT       = MEM_RD_LAT;
  localparam int AUX_MAX_WAIT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        cpu_req, cpu_we, aux_req, aux_we;
  logic [15:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
  logic        cpu_gnt, cpu_rvalid, aux_gnt, aux_rvalid, mem_wen;
  logic [15:0] cpu_rdata, aux_rdata, mem_raddr, mem_rdata, mem_waddr, mem_wdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_aux_stall, stat_cpu_stall, stat_force;
`endif

  mem_port_arbiter #(.RD_LAT(RD_LAT), .AUX_MAX_WAIT(AUX_MAX_WAIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .aux_req    (aux_req),
    .aux_we     (aux_we),
    .aux_addr   (aux_addr),
    .aux_wdata  (aux_wdata),
    .aux_gnt    (aux_gnt),
    .aux_rvalid (aux_rvalid),
    .aux_rdata  (aux_rdata),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_aux_stall (stat_aux_stall),
    .stat_cpu_stall (stat_cpu_stall),
    .stat_force     (stat_force)
`endif
  );

  // ---------------- behavioural memory (bit 15 ignored) ----------------
  logic [15:0] mem [0:32767];
  logic [15:0] mem_r1 = 16'h0000;
  logic [15:0] mem_rdata_q = 16'h0000;
  assign mem_rdata = mem_rdata_q;

  always @(posedge clk) begin
    mem_rdata_q <= mem[mem_r1[14:0]];
    mem_r1      <= mem_raddr;
    if (mem_wen) mem[mem_waddr[14:0]] <= mem_wdata;
  end

  // ---------------- counters and tables ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] pre_tab [64];
  logic [15:0] rd_tab  [3];

  // ---------------- driver tasks ----------------
  task automatic drive_cpu(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic drive_aux(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    aux_req = r; aux_we = w; aux_addr = a; aux_wdata = d;
  endtask

  task automatic drive_idle();
    drive_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
    drive_aux(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / reference model ----------------
  int          exp_due_q [$];
  logic        exp_own_q [$];
  logic [15:0] exp_q     [$];
  int          m_wait = 0;
  logic [15:0] m_last_raddr = 16'h0000;
  int          cyc = 0;
  int          m_aux_stall = 0, m_cpu_stall = 0, m_force = 0;
  logic        e_force, e_aux, e_cpu, e_we, e_rd, e_wr, e_cv, e_av;
  logic [15:0] e_addr, e_wdata, e_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_due_q.delete(); exp_own_q.delete(); exp_q.delete();
      m_wait = 0; m_last_raddr = 16'h0000;
      m_aux_stall = 0; m_cpu_stall = 0; m_force = 0;
    end else begin
      e_force = (m_wait == AUX_MAX_WAIT);
      e_aux   = aux_req && (!cpu_req || e_force);
      e_cpu   = cpu_req && !e_aux;
      e_we    = e_aux ? aux_we : cpu_we;
      e_addr  = e_aux ? aux_addr : cpu_addr;
      e_wdata = e_aux ? aux_wdata : cpu_wdata;
      e_rd    = (e_aux || e_cpu) && !e_we;
      e_wr    = (e_aux || e_cpu) && e_we;

      total += 2;
      if (cpu_gnt !== e_cpu) begin bad++; $display("FAIL sb_cpu_gnt cyc=%0d got=%b want=%b", cyc, cpu_gnt, e_cpu); end
      if (aux_gnt !== e_aux) begin bad++; $display("FAIL sb_aux_gnt cyc=%0d got=%b want=%b", cyc, aux_gnt, e_aux); end
      total++;
      if (mem_wen !== e_wr) begin bad++; $display("FAIL sb_mem_wen cyc=%0d got=%b want=%b", cyc, mem_wen, e_wr); end
      if (e_wr) begin
        total++;
        if (mem_waddr !== e_addr || mem_wdata !== e_wdata) begin
          bad++; $display("FAIL sb_write cyc=%0d got=%h/%h want=%h/%h", cyc, mem_waddr, mem_wdata, e_addr, e_wdata);
        end
      end
      if (e_rd) m_last_raddr = e_addr;
      total++;
      if (mem_raddr !== m_last_raddr) begin bad++; $display("FAIL sb_mem_raddr cyc=%0d got=%h want=%h", cyc, mem_raddr, m_last_raddr); end

      e_cv = 1'b0; e_av = 1'b0; e_data = 16'h0000;
      if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
        if (exp_own_q[0] == OWN_CPU) e_cv = 1'b1; else e_av = 1'b1;
        e_data = exp_q[0];
        void'(exp_due_q.pop_front()); void'(exp_own_q.pop_front()); void'(exp_q.pop_front());
      end
      total += 2;
      if (cpu_rvalid !== e_cv) begin bad++; $display("FAIL sb_cpu_rvalid cyc=%0d got=%b want=%b", cyc, cpu_rvalid, e_cv); end
      if (aux_rvalid !== e_av) begin bad++; $display("FAIL sb_aux_rvalid cyc=%0d got=%b want=%b", cyc, aux_rvalid, e_av); end
      if (e_cv) begin
        total++;
        if (cpu_rdata !== e_data) begin bad++; $display("FAIL sb_cpu_rdata cyc=%0d got=%h want=%h", cyc, cpu_rdata, e_data); end
      end
      if (e_av) begin
        total++;
        if (aux_rdata !== e_data) begin bad++; $display("FAIL sb_aux_rdata cyc=%0d got=%h want=%h", cyc, aux_rdata, e_data); end
      end
      if (e_rd) begin
        exp_due_q.push_back(cyc + RD_LAT);
        exp_own_q.push_back(e_aux ? OWN_AUX : OWN_CPU);
        exp_q.push_back(mem[e_addr[14:0]]);
      end

`ifdef MEM_ARB_STATS_EN
      total++;
      if (int'(stat_aux_stall) != m_aux_stall || int'(stat_cpu_stall) != m_cpu_stall || int'(stat_force) != m_force) begin
        bad++;
        $display("FAIL sb_stats cyc=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", cyc,
                 stat_aux_stall, stat_cpu_stall, stat_force, m_aux_stall, m_cpu_stall, m_force);
      end
      if (aux_req && !e_aux && m_aux_stall < 65535) m_aux_stall++;
      if (cpu_req && !e_cpu && m_cpu_stall < 65535) m_cpu_stall++;
      if (e_aux && e_force && m_force < 65535) m_force++;
`endif

      if (aux_req && !e_aux) m_wait = (m_wait >= AUX_MAX_WAIT) ? AUX_MAX_WAIT : m_wait + 1;
      else m_wait = 0;
    end
    cyc++;
  end

  // ---------------- scenario tasks ----------------
  task automatic check_all_zero(input string tag);
    total++;
    if (cpu_gnt !== 1'b0 || aux_gnt !== 1'b0 || mem_wen !== 1'b0 || cpu_rvalid !== 1'b0 ||
        aux_rvalid !== 1'b0 || mem_raddr !== 16'h0 || mem_waddr !== 16'h0 || mem_wdata !== 16'h0) begin
      bad++;
      $display("FAIL %s got gnt=%b%b wen=%b rv=%b%b raddr=%h waddr=%h wdata=%h want all 0", tag,
               cpu_gnt, aux_gnt, mem_wen, cpu_rvalid, aux_rvalid, mem_raddr, mem_waddr, mem_wdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_cpu(1'b1, 1'b1, 16'h00aa, 16'h5555);
    drive_aux(1'b1, 1'b0, 16'h00bb, 16'h6666);
    repeat (2) @(negedge clk);
    check_all_zero("reset_outputs");
    tick();
    rst_n = 1'b1;
    drive_idle();
    tick();
  endtask

  // Fills words 0..63 through the cpu write port.
  task automatic preload();
    for (int a = 0; a < 64; a++) begin
      if (a >= 16 && a <= 18) pre_tab[a] = rd_tab[a-16];
      else pre_tab[a] = 16'($urandom);
      drive_cpu(1'b1, 1'b1, 16'(a), pre_tab[a]);
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_cpu_reads();
    for (int k = 0; k < 6; k++) begin
      if (k < 3) drive_cpu(1'b1, 1'b0, 16'(16'h0010 + k), 16'h0000);
      else drive_idle();
      @(negedge clk);
      total += 3;
      if (cpu_gnt !== (k < 3)) begin bad++; $display("FAIL cpu_reads_gnt k=%0d got=%b want=%b", k, cpu_gnt, (k < 3)); end
      if (cpu_rvalid !== (k >= 2 && k <= 4)) begin bad++; $display("FAIL cpu_reads_rvalid k=%0d got=%b want=%b", k, cpu_rvalid, (k >= 2 && k <= 4)); end
      if (aux_rvalid !== 1'b0) begin bad++; $display("FAIL cpu_reads_aux_rvalid k=%0d got=%b want=0", k, aux_rvalid); end
      if (k >= 2 && k <= 4) begin
        total++;
        if (cpu_rdata !== rd_tab[k-2]) begin bad++; $display("FAIL cpu_reads_data k=%0d got=%h want=%h", k, cpu_rdata, rd_tab[k-2]); end
      end
      tick();
    end
  endtask

  task automatic test_aux_write_read();
    for (int k = 0; k < 5; k++) begin
      drive_cpu(1'b0, 1'b0, 16'h0000, 16'h0000);
      if (k == 0) drive_aux(1'b1, 1'b1, 16'h0100, 16'hbeef);
      else if (k == 1) drive_aux(1'b1, 1'b0, 16'h0100, 16'h0000);
      else drive_aux(1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      total += 4;
      if (aux_gnt !== (k < 2)) begin bad++; $display("FAIL aux_wr_rd_gnt k=%0d got=%b want=%b", k, aux_gnt, (k < 2)); end
      if (mem_wen !== (k == 0)) begin bad++; $display("FAIL aux_wr_rd_wen k=%0d got=%b want=%b", k, mem_wen, (k == 0)); end
      if (aux_rvalid !== (k == 3)) begin bad++; $display("FAIL aux_wr_rd_rvalid k=%0d got=%b want=%b", k, aux_rvalid, (k == 3)); end
      if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL aux_wr_rd_cpu_rvalid k=%0d got=%b want=0", k, cpu_rvalid); end
      if (k == 3) begin
        total++;
        if (aux_rdata !== 16'hbeef) begin bad++; $display("FAIL aux_wr_rd_data got=%h want=beef", aux_rdata); end
      end
      tick();
    end
  endtask

  task automatic test_interleave();
    for (int k = 0; k < 5; k++) begin
      drive_idle();
      if (k == 0) drive_cpu(1'b1, 1'b0, 16'h0020, 16'h0000);
      if (k == 1) drive_aux(1'b1, 1'b0, 16'h0021, 16'h0000);
      @(negedge clk);
      total += 2;
      if (cpu_rvalid !== (k == 2)) begin bad++; $display("FAIL interleave_cpu_rvalid k=%0d got=%b want=%b", k, cpu_rvalid, (k == 2)); end
      if (aux_rvalid !== (k == 3)) begin bad++; $display("FAIL interleave_aux_rvalid k=%0d got=%b want=%b", k, aux_rvalid, (k == 3)); end
      if (k == 2) begin
        total++;
        if (cpu_rdata !== pre_tab[32]) begin bad++; $display("FAIL interleave_cpu_data got=%h want=%h", cpu_rdata, pre_tab[32]); end
      end
      if (k == 3) begin
        total++;
        if (aux_rdata !== pre_tab[33]) begin bad++; $display("FAIL interleave_aux_data got=%h want=%h", aux_rdata, pre_tab[33]); end
      end
      tick();
    end
  endtask

  task automatic test_contention();
`ifdef MEM_ARB_STATS_EN
    int s_aux, s_cpu, s_frc;
`endif
    drive_cpu(1'b1, 1'b0, 16'h0005, 16'h0000);
    drive_aux(1'b1, 1'b0, 16'h0006, 16'h0000);
    for (int k = 0; k < 37; k++) begin
      @(negedge clk);
`ifdef MEM_ARB_STATS_EN
      if (k == 0) begin s_aux = int'(stat_aux_stall); s_cpu = int'(stat_cpu_stall); s_frc = int'(stat_force); end
      if (k == 18) begin
        total++;
        if (int'(stat_force) - s_frc != 2 || int'(stat_aux_stall) - s_aux != 16 || int'(stat_cpu_stall) - s_cpu != 2) begin
          bad++;
          $display("FAIL contention_stats got force=%0d aux=%0d cpu=%0d want 2/16/2",
                   int'(stat_force) - s_frc, int'(stat_aux_stall) - s_aux, int'(stat_cpu_stall) - s_cpu);
        end
      end
`endif
      if (k < 36) begin
        total += 2;
        if (aux_gnt !== (k % 9 == 8)) begin bad++; $display("FAIL contention_aux_gnt k=%0d got=%b want=%b", k, aux_gnt, (k % 9 == 8)); end
        if (cpu_gnt !== (k % 9 != 8)) begin bad++; $display("FAIL contention_cpu_gnt k=%0d got=%b want=%b", k, cpu_gnt, (k % 9 != 8)); end
      end
      tick();
    end
    drive_idle();
    repeat (3) tick();
  endtask

  task automatic test_mid_reset();
    drive_cpu(1'b1, 1'b0, 16'h0010, 16'h0000);
    tick();
    drive_cpu(1'b1, 1'b0, 16'h0011, 16'h0000);
    tick();
    rst_n = 1'b0;
    drive_cpu(1'b1, 1'b1, 16'h0033, 16'h7777);
    drive_aux(1'b1, 1'b0, 16'h0034, 16'h0000);
    #1;
    check_all_zero("mid_reset_outputs");
    @(negedge clk);
    check_all_zero("mid_reset_outputs_negedge");
    tick();
    rst_n = 1'b1;
    drive_idle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (cpu_rvalid !== 1'b0 || aux_rvalid !== 1'b0) begin
        bad++; $display("FAIL mid_reset_no_rvalid k=%0d got=%b%b want=00", k, cpu_rvalid, aux_rvalid);
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      if (k == 0) drive_cpu(1'b1, 1'b0, 16'h0012, 16'h0000);
      else drive_idle();
      @(negedge clk);
      total++;
      if (cpu_rvalid !== (k == 2)) begin bad++; $display("FAIL mid_reset_read_rvalid k=%0d got=%b want=%b", k, cpu_rvalid, (k == 2)); end
      if (k == 2) begin
        total++;
        if (cpu_rdata !== pre_tab[18]) begin bad++; $display("FAIL mid_reset_read_data got=%h want=%h", cpu_rdata, pre_tab[18]); end
      end
      tick();
    end
  endtask

  // Random requests with hold-until-grant behaviour (occasionally dropped);
  // checking is done entirely by the scoreboard.
  task automatic test_random();
    logic cg, ag;
    logic [15:0] a;
    cg = 1'b1; ag = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (!(cpu_req && !cg && $urandom_range(0, 3) != 0)) begin
        a = 16'($urandom_range(0, 63)); a[15] = 1'($urandom_range(0, 1));
        drive_cpu(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 2) == 0), a, 16'($urandom));
      end
      if (!(aux_req && !ag && $urandom_range(0, 7) != 0)) begin
        a = 16'($urandom_range(0, 63)); a[15] = 1'($urandom_range(0, 1));
        drive_aux(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom));
      end
      @(negedge clk);
      cg = cpu_gnt; ag = aux_gnt;
      tick();
    end
    drive_idle();
  endtask

  task automatic test_drain();
    repeat (RD_LAT + 3) tick();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL drain_pending got=%0d want=0", exp_q.size()); end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rd_tab[0] = 16'h1234; rd_tab[1] = 16'h5678; rd_tab[2] = 16'h9abc;
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    preload();
    test_cpu_reads();
    test_aux_write_read();
    test_interleave();
    test_contention();
    test_mid_reset();
    test_random();
    test_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the data-side port of the pipeline CPU's dual-port program/data memory between two requesters.
- The two requesters are the CPU load/store stage (cpu) and an auxiliary master (aux), such as the UART program loader or the debug probe.
- The arbiter drives the memory's read port 1 and its single write port.
- It tracks in-flight reads through the memory's fixed 2-cycle read latency and routes returned data to the requester that issued each read.

Parameters:
- RD_LAT, 2, memory read latency in cycles from address presented to data valid. Sizes the in-flight tag pipeline.
- AUX_MAX_WAIT, 8, number of consecutive cycles aux may be denied while requesting before it is force-granted. Legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  cpu request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  16  word address
- cpu_wdata  in  16  write data
- cpu_gnt  out  1  request accepted this cycle (combinational)
- cpu_rvalid  out  1  read data valid for cpu
- cpu_rdata  out  16  read data
- aux_req, aux_we, aux_addr[15:0], aux_wdata[15:0]  in  same meanings as the cpu inputs, for aux
- aux_gnt, aux_rvalid, aux_rdata[15:0]  out  same meanings as the cpu outputs, for aux
- mem_raddr  out  16  to memory read port 1 address
- mem_rdata  in  16  from memory read port 1 data
- mem_wen  out  1  memory write enable
- mem_waddr  out  16  memory write address
- mem_wdata  out  16  memory write data

Behaviour:
- Reset (asserting rst_n low, asynchronous):
  - Tag pipeline cleared; wait counter cleared.
  - While rst_n is low, cpu_gnt, aux_gnt, mem_wen, cpu_rvalid and aux_rvalid are all 0.
  - mem_raddr, mem_waddr and mem_wdata are 0.
- Arbitration (combinational from the request inputs and wait_cnt):
  - Default is fixed cpu priority.
  - aux_gnt = aux_req & (~cpu_req | force_aux), where force_aux = (wait_cnt == AUX_MAX_WAIT).
  - cpu_gnt = cpu_req & ~(aux_gnt & cpu_req).
  - Exactly one grant is active per cycle at most.
- Wait counter (register, 8 bits):
  - Increments when aux_req & ~aux_gnt, saturating at AUX_MAX_WAIT.
  - Clears on aux_gnt, or when aux_req is low.
- Issue:
  - The granted request drives mem_raddr (reads) or mem_wen/mem_waddr/mem_wdata (writes) in the same cycle.
  - With no grant: mem_wen = 0; mem_raddr holds the last granted read address.
- Writes: complete at the next edge; no response is returned.
- Reads:
  - A tag {valid, owner} is pushed into an RD_LAT-deep shift register on each granted read.
  - A granted write or an idle cycle pushes {0, x}.
  - When the tag at the tail is valid, the owner's rvalid is 1 for exactly one cycle.
  - A read granted in cycle t produces rvalid in cycle t+RD_LAT.
- Read data: cpu_rdata and aux_rdata both wire directly to mem_rdata. Consumers qualify the data with rvalid.
- Throughput: one access per cycle; back-to-back reads are fully pipelined.
- Address width: 16-bit word addresses are passed unmodified. The memory ignores bit 15.
- Read-after-write: a read of an address written in the immediately preceding cycle returns the new data, because the memory reads one cycle after capture. The arbiter does no forwarding.
- Mid-operation reset: in-flight reads are discarded; no rvalid is emitted after reset deasserts.
- Requesters hold req and request fields stable until granted. Dropping req before grant is legal and cancels the request.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, three extra output ports are added:
  - stat_aux_stall[15:0]: cycles with aux_req & ~aux_gnt.
  - stat_cpu_stall[15:0]: cycles with cpu_req & ~cpu_gnt.
  - stat_force[15:0]: forced aux grants.
- All three counters saturate at 16'hffff and clear on reset.
- When the macro is undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package:
  - owner encoding constants OWN_CPU = 1'b0, OWN_AUX = 1'b1;
  - the read-latency constant MEM_RD_LAT = 2, which the memory and this arbiter both use.
- One sub-module, mem_rd_tag_pipe: parameterised RD_LAT-deep shift register of {valid, owner}, with asynchronous clear.

Test Plan:
- cpu-only reads at addresses 0x0010, 0x0011, 0x0012 on consecutive cycles -> cpu_gnt=1 each cycle; cpu_rvalid=1 in cycles t+2..t+4 with preloaded data 0x1234, 0x5678, 0x9abc; aux_rvalid stays 0.
- aux write 0xbeef to 0x0100 with cpu idle, then aux read 0x0100 the next cycle -> aux_gnt both cycles; aux_rvalid two cycles after the read with aux_rdata = 0xbeef.
- cpu_req and aux_req held continuously (AUX_MAX_WAIT=8) -> cpu granted 8 cycles, aux granted on the 9th, then cpu 8 more; pattern repeats; wait_cnt never exceeds 8.
- Interleaved cpu read 0x0020 then aux read 0x0021 on consecutive cycles -> cpu_rvalid at t+2 with data[0x20], aux_rvalid at t+3 with data[0x21]; never both in the same cycle.
- Issue two reads, then pulse rst_n low for one cycle before the data returns -> all outputs are 0 during reset; no rvalid afterwards; the next cpu read returns correctly.
- With MEM_ARB_STATS_EN defined, run the contention test for 18 cycles -> stat_force=2, stat_aux_stall=16, stat_cpu_stall=2.
